// File: rtl/max10nios_pio_pkg.sv
// Shared constants for the NIOS PIO blocks: the 2-bit word address map and
// the edge-detect mode encoding.
package max10nios_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_DIR     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISING  = 2'd0,
        EDGE_FALLING = 2'd1,
        EDGE_ANY     = 2'd2
    } edge_type_e;

    function automatic logic [31:0] detect_edges(input edge_type_e kind,
                                                 input logic [31:0] cur,
                                                 input logic [31:0] prev);
        case (kind)
            EDGE_RISING:  return cur & ~prev;
            EDGE_FALLING: return ~cur & prev;
            default:      return cur ^ prev;
        endcase
    endfunction

endpackage

// File: rtl/max10nios_bit_sync.sv
// One-bit input conditioner: SYNC_STAGES-deep synchroniser, followed by a
// stable-count debounce filter when MAX10NIOS_ACK_DEBOUNCE_EN is defined.
module max10nios_bit_sync
    import max10nios_pio_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef MAX10NIOS_ACK_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 16
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_bit;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_bit = sync_q[SYNC_STAGES-1];

`ifdef MAX10NIOS_ACK_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             filt_q;
    logic             filt_d;

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_bit != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync_bit;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign dout = filt_q;
`else
    assign dout = sync_bit;
`endif

endmodule

// File: rtl/max10nios_ack_pio.sv
// Avalon-MM acknowledge input PIO: synchronised inputs, sticky edge capture,
// maskable level irq. Optional debounce via MAX10NIOS_ACK_DEBOUNCE_EN.
module max10nios_ack_pio
    import max10nios_pio_pkg::*;
#(
    parameter int WIDTH           = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        EDGE_TYPE < 0 || EDGE_TYPE > 2 ||
        DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_params
        $error("max10nios_ack_pio: parameter out of range");
    end

    localparam edge_type_e EDGE_SEL = edge_type_e'(2'(EDGE_TYPE));
    localparam int PRIME_W = $clog2(SYNC_STAGES + 2);
    localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0]   filt;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [PRIME_W-1:0] prime_q, prime_d;
    logic [WIDTH-1:0]   irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0]   edge_capture_q, edge_capture_d;
    logic [31:0]        readdata_q, readdata_d;
    logic               irq_q, irq_d;
    logic [WIDTH-1:0]   edges;
    logic               rd_en;
    logic               wr_en;
    logic               primed;
    logic               unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        max10nios_bit_sync #(
            .SYNC_STAGES     (SYNC_STAGES)
`ifdef MAX10NIOS_ACK_DEBOUNCE_EN
            ,
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`endif
        ) u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[i]),
            .dout    (filt[i])
        );
    end

    assign unused_wdata = ^writedata;

    always_comb begin
        rd_en  = chipselect & ~read_n;
        wr_en  = chipselect & ~write_n;
        primed = (prime_q == PRIME_DONE);
        edges  = WIDTH'(detect_edges(EDGE_SEL, 32'(filt), 32'(prev_q)));

        prev_d  = filt;
        // The prime counter holds off capture until the synchroniser and
        // prev register carry real post-reset samples.
        prime_d = primed ? prime_q : prime_q + PRIME_W'(1);

        irq_mask_d = irq_mask_q;
        if (wr_en && address == ADDR_IRQMASK) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end

        // Clear first, then OR in new edges so a coincident edge survives.
        edge_capture_d = edge_capture_q;
        if (wr_en && address == ADDR_EDGECAP) begin
            edge_capture_d = edge_capture_d & ~writedata[WIDTH-1:0];
        end
        if (primed) begin
            edge_capture_d = edge_capture_d | edges;
        end

        readdata_d = readdata_q;
        if (rd_en) begin
            case (address)
                ADDR_DATA:    readdata_d = 32'(filt);
                ADDR_DIR:     readdata_d = '0;
                ADDR_IRQMASK: readdata_d = 32'(irq_mask_q);
                ADDR_EDGECAP: readdata_d = 32'(edge_capture_q);
                default:      readdata_d = '0;
            endcase
        end

        irq_d = |(edge_capture_q & irq_mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q         <= '0;
            prime_q        <= '0;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            readdata_q     <= '0;
            irq_q          <= 1'b0;
        end else begin
            prev_q         <= prev_d;
            prime_q        <= prime_d;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
            irq_q          <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_max10nios_ack_pio.sv
// Bench for max10nios_ack_pio: a rising-edge and an any-edge instance share one
// bus, checked every cycle against an in-bench history model plus literal vectors.
module tb_max10nios_ack_pio;

    localparam int W = 4;
    localparam int S = 2;
    localparam int D = 16;
`ifdef MAX10NIOS_ACK_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   address = 2'd0;
    logic         chipselect = 1'b0;
    logic         read_n = 1'b1;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = 32'd0;
    logic [W-1:0] in_port = '1;
    logic [31:0]  rd_r, rd_a;
    logic         irq_r, irq_a;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    max10nios_ack_pio #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(D)) dut_r (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_r), .irq(irq_r));

    max10nios_ack_pio #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(D)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_a), .irq(irq_a));

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // History of in_port samples and filtered values, indexed by clock edges since reset.
    int           k_m = 0;
    logic [W-1:0] in_hist[$];
    logic [W-1:0] filt_hist[$];
    logic [W-1:0] fm = '0;
    int           run_m[W];
    logic [W-1:0] mask_m[2];
    logic [W-1:0] cap_m[2];
    logic [31:0]  rd_m[2];
    logic         irq_m[2];

    function automatic logic [W-1:0] syncv(input int m);
        if (m >= S) return in_hist[m-S];
        return '0;
    endfunction

    function automatic logic [W-1:0] filt_at(input int m);
        if (m >= 1) return filt_hist[m-1];
        return '0;
    endfunction

    function automatic logic [W-1:0] edges_of(input int kind, input logic [W-1:0] cur,
                                               input logic [W-1:0] prv);
        if (kind == 0) return cur & ~prv;
        if (kind == 1) return ~cur & prv;
        return cur ^ prv;
    endfunction

    initial begin
        logic [W-1:0] fq, pq, s_old, fnew, ev;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                k_m = 0;
                in_hist.delete();
                filt_hist.delete();
                fm = '0;
                for (int i = 0; i < W; i++) run_m[i] = 0;
                for (int e = 0; e < 2; e++) begin
                    mask_m[e] = '0; cap_m[e] = '0; rd_m[e] = '0; irq_m[e] = 1'b0;
                end
            end else begin
                k_m = k_m + 1;
                fq = filt_at(k_m - 1);
                pq = filt_at(k_m - 2);
                s_old = syncv(k_m - 1);
                in_hist.push_back(in_port);
                if (DEB) begin
                    for (int i = 0; i < W; i++) begin
                        if (s_old[i] != fm[i]) begin
                            run_m[i] = run_m[i] + 1;
                            if (run_m[i] == D) begin
                                fm[i] = s_old[i];
                                run_m[i] = 0;
                            end
                        end else begin
                            run_m[i] = 0;
                        end
                    end
                    fnew = fm;
                end else begin
                    fnew = syncv(k_m);
                end
                filt_hist.push_back(fnew);
                for (int e = 0; e < 2; e++) begin
                    ev = edges_of((e == 0) ? 0 : 2, fq, pq);
                    if (chipselect && !read_n) begin
                        case (address)
                            2'd0:    rd_m[e] = 32'(fq);
                            2'd2:    rd_m[e] = 32'(mask_m[e]);
                            2'd3:    rd_m[e] = 32'(cap_m[e]);
                            default: rd_m[e] = 32'd0;
                        endcase
                    end
                    irq_m[e] = |(cap_m[e] & mask_m[e]);
                    if (chipselect && !write_n && address == 2'd2) mask_m[e] = writedata[W-1:0];
                    if (chipselect && !write_n && address == 2'd3) cap_m[e] = cap_m[e] & ~writedata[W-1:0];
                    if (k_m - 1 >= S + 1) cap_m[e] = cap_m[e] | ev;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("model_rd_rise", rd_r, rd_m[0]);
                check("model_irq_rise", 32'(irq_r), 32'(irq_m[0]));
                check("model_rd_any", rd_a, rd_m[1]);
                check("model_irq_any", 32'(irq_a), 32'(irq_m[1]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] dr, output logic [31:0] da);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1;
        dr = rd_r;
        da = rd_a;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic release_reset();
        #2 reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic mid_reset_test(input int settle, input logic [31:0] data_after);
        logic [31:0] vr, va;
        in_port = '0;
        idle(settle);
        bus_write(2'd3, 32'hF);
        bus_write(2'd2, 32'h3);
        in_port = 4'h3;
        idle(settle);
        bus_read(2'd3, vr, va);
        check("rst_cap_before_r", vr, 32'h3);
        check("rst_cap_before_a", va, 32'h3);
        check("rst_irq_before_r", 32'(irq_r), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_irq_now_r", 32'(irq_r), 32'd0);
        check("rst_irq_now_a", 32'(irq_a), 32'd0);
        check("rst_rd_now_r", rd_r, 32'd0);
        @(negedge clk);
        idle(2);
        release_reset();
        idle(8);
        bus_read(2'd3, vr, va);
        check("rst_cap_after_r", vr, 32'd0);
        check("rst_cap_after_a", va, 32'd0);
        bus_read(2'd2, vr, va);
        check("rst_mask_after_r", vr, 32'd0);
        bus_read(2'd0, vr, va);
        check("rst_data_after_r", vr, data_after);
        check("rst_irq_after_r", 32'(irq_r), 32'd0);
    endtask

    initial begin
        logic [31:0] vr, va;
        idle(2);
        chk_en = 1'b1;
`ifndef MAX10NIOS_ACK_DEBOUNCE_EN
        // Inputs high through reset never capture.
        in_port = 4'hF;
        release_reset();
        idle(10);
        bus_read(2'd0, vr, va);
        check("t1_data_r", vr, 32'h0000000F);
        check("t1_data_a", va, 32'h0000000F);
        bus_read(2'd3, vr, va);
        check("t1_cap_r", vr, 32'd0);
        check("t1_cap_a", va, 32'd0);
        check("t1_irq_r", 32'(irq_r), 32'd0);
        check("t1_irq_a", 32'(irq_a), 32'd0);

        in_port = '0;
        idle(6);
        bus_write(2'd3, 32'hF);

        // Rising edge on bit 0: capture at edge 3, irq at edge 4, W1C drops irq a cycle later.
        bus_write(2'd2, 32'h1);
        in_port = 4'h1;
        idle(2);
        bus_read(2'd3, vr, va);
        check("t2_cap_edge3_r", vr, 32'd0);
        check("t2_irq_edge3_r", 32'(irq_r), 32'd0);
        bus_read(2'd3, vr, va);
        check("t2_cap_edge4_r", vr, 32'h1);
        check("t2_cap_edge4_a", va, 32'h1);
        check("t2_irq_edge4_r", 32'(irq_r), 32'd1);
        bus_write(2'd3, 32'h1);
        check("t2_irq_clr_same_r", 32'(irq_r), 32'd1);
        idle(1);
        check("t2_irq_clr_next_r", 32'(irq_r), 32'd0);
        check("t2_irq_clr_next_a", 32'(irq_a), 32'd0);

        // Edge on bit 2 coinciding with W1C of bit 2: set wins.
        bus_write(2'd3, 32'hF);
        in_port = 4'h5;
        idle(2);
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, vr, va);
        check("t3_setwins_r", vr, 32'h4);
        check("t3_setwins_a", va, 32'h4);

        // Capture with mask clear, then unmask: irq follows the mask write by one cycle.
        bus_write(2'd3, 32'hF);
        bus_write(2'd2, 32'h0);
        in_port = 4'h7;
        idle(4);
        bus_read(2'd3, vr, va);
        check("t4_cap_r", vr, 32'h2);
        check("t4_cap_a", va, 32'h2);
        check("t4_irq_masked_a", 32'(irq_a), 32'd0);
        bus_write(2'd2, 32'h2);
        check("t4_irq_same_a", 32'(irq_a), 32'd0);
        idle(1);
        check("t4_irq_next_a", 32'(irq_a), 32'd1);
        check("t4_irq_next_r", 32'(irq_r), 32'd1);

        mid_reset_test(6, 32'h3);
`else
        in_port = '0;
        release_reset();
        idle(10);
        bus_read(2'd0, vr, va);
        check("db_data_idle_r", vr, 32'd0);
        bus_write(2'd2, 32'h1);

        // A 10-cycle pulse is shorter than the debounce window.
        in_port = 4'h1;
        idle(10);
        in_port = 4'h0;
        idle(30);
        bus_read(2'd3, vr, va);
        check("db_short_cap_r", vr, 32'd0);
        check("db_short_cap_a", va, 32'd0);
        bus_read(2'd0, vr, va);
        check("db_short_data_r", vr, 32'd0);

        // A long pulse captures at edge S+1+D.
        in_port = 4'h1;
        idle(S + D);
        bus_read(2'd3, vr, va);
        check("db_long_cap_early_r", vr, 32'd0);
        bus_read(2'd3, vr, va);
        check("db_long_cap_r", vr, 32'h1);
        check("db_long_cap_a", va, 32'h1);
        check("db_long_irq_r", 32'(irq_r), 32'd1);
        in_port = 4'h0;
        idle(D + 6);

        mid_reset_test(D + 6, 32'd0);
`endif
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
